dmem_ctrl: RTL

Parametrised data-memory block for the DLX MEM stage. It supports byte, halfword and word loads and stores (DLX LB/LBU/LH/LHU/LW/SB/SH/SW) with sign or zero extension, and registers read data with one-cycle latency. It flags misaligned and out-of-range accesses. After reset it zero-fills the array with a sequential clear engine and raises `busy` so the pipeline stalls until memory is valid.

---
 rtl/dmem_if.sv | 28 ++
 rtl/dmem_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Request/response bundle between the MEM stage and the data memory.
// A load or store is accepted at a rising edge when mem_read or mem_write is high and busy is low.
// While busy is high the requester must hold its request; responses are registered and appear after the accepting edge.
interface dmem_if #(
  parameter int ADDR_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_size;
  logic              mem_unsigned;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic [31:0]       read_data;
  logic              read_valid;
  logic              busy;
  logic              misalign;
  logic              oob;

  modport master (
    output mem_read, mem_write, mem_size, mem_unsigned, address, write_data,
    input  read_data, read_valid, busy, misalign, oob
  );

  modport slave (
    input  mem_read, mem_write, mem_size, mem_unsigned, address, write_data,
    output read_data, read_valid, busy, misalign, oob
  );
endinterface

// File: rtl/dmem_ctrl.sv
// DLX data memory: byte/half/word loads and stores, registered read data,
// fault flags, and a post-reset zero-fill engine that holds busy high.
module dmem_ctrl #(
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus,
  output logic   dbg_state_o
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clear_ptr_q, clear_ptr_d;

  logic [31:0]       mem_q [DEPTH];

  logic [31:0]       read_data_q, read_data_d;
  logic              read_valid_q, read_valid_d;
  logic              misalign_q, misalign_d;
  logic              oob_q, oob_d;

  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        byte_off;
  logic              addr_oob;
  logic              addr_mis;
  logic              req;
  logic              do_load;
  logic              do_store;
  logic [31:0]       rd_word;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       load_value;
  logic [3:0]        store_be;
  logic [31:0]       store_wdata;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;

  assign word_idx = bus.address[2 +: IDX_W];
  assign byte_off = bus.address[1:0];
  assign addr_oob = |bus.address[ADDR_W-1:IDX_W+2];

  // Alignment depends only on size and the low address bits; size 11 is never legal.
  always_comb begin
    addr_mis = 1'b0;
    case (bus.mem_size)
      2'b00:   addr_mis = 1'b0;
      2'b01:   addr_mis = byte_off[0];
      2'b10:   addr_mis = |byte_off;
      default: addr_mis = 1'b1;
    endcase
  end

  assign req      = (bus.mem_read || bus.mem_write) && (state_q == ST_RUN);
  assign do_load  = req && bus.mem_read  && !addr_oob && !addr_mis;
  assign do_store = req && bus.mem_write && !addr_oob && !addr_mis;

  // Combinational array read; the write below lands at the edge, so a
  // same-cycle load of the stored word sees the old contents.
  assign rd_word = mem_q[word_idx];

  always_comb begin
    lane_byte = rd_word[7:0];
    case (byte_off)
      2'd0:    lane_byte = rd_word[7:0];
      2'd1:    lane_byte = rd_word[15:8];
      2'd2:    lane_byte = rd_word[23:16];
      default: lane_byte = rd_word[31:24];
    endcase
  end

  assign lane_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_value = rd_word;
    case (bus.mem_size)
      2'b00:   load_value = {{24{~bus.mem_unsigned & lane_byte[7]}}, lane_byte};
      2'b01:   load_value = {{16{~bus.mem_unsigned & lane_half[15]}}, lane_half};
      default: load_value = rd_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = bus.write_data;
    case (bus.mem_size)
      2'b00: begin
        store_be    = 4'b0001 << byte_off;
        store_wdata = {4{bus.write_data[7:0]}};
      end
      2'b01: begin
        store_be    = byte_off[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{bus.write_data[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = bus.write_data;
      end
    endcase
  end

  always_comb begin
    mem_we    = do_store;
    mem_widx  = word_idx;
    mem_be    = store_be;
    mem_wdata = store_wdata;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_widx  = clear_ptr_q;
      mem_be    = 4'b1111;
      mem_wdata = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem_q[mem_widx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clear_ptr_d = clear_ptr_q + IDX_W'(1);
        if (clear_ptr_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // oob outranks misalign when both apply.
  always_comb begin
    read_data_d  = do_load ? load_value : read_data_q;
    read_valid_d = do_load;
    oob_d        = req && addr_oob;
    misalign_d   = req && !addr_oob && addr_mis;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clear_ptr_q  <= '0;
      read_data_q  <= 32'h0;
      read_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      oob_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_ptr_q  <= clear_ptr_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      misalign_q   <= misalign_d;
      oob_q        <= oob_d;
    end
  end

  assign bus.read_data  = read_data_q;
  assign bus.read_valid = read_valid_q;
  assign bus.misalign   = misalign_q;
  assign bus.oob        = oob_q;
  assign bus.busy       = (state_q == ST_CLEAR);
  assign dbg_state_o    = (state_q == ST_CLEAR);

endmodule
